// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and width-derivation helpers for the
// convolution accumulate engine.
package conv_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int WGT_W_DEF  = 8;
  localparam int CH_DEF     = 2;
  localparam int TAPS_DEF   = 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // Index width that never collapses to zero bits for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_w(input int dw, input int ww, input int ch, input int taps);
    return dw + ww + $clog2(ch * taps);
  endfunction

  function automatic int out_w(input int dw, input int ww);
    return dw + ww + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// One kernel tap: CH signed activation x weight products, summed at ACC_W.
module conv_mac #(
  parameter int DATA_W = 13,
  parameter int WGT_W  = 8,
  parameter int CH     = 2,
  parameter int ACC_W  = 24
) (
  input  logic [CH*DATA_W-1:0]      data,
  input  logic [CH-1:0][WGT_W-1:0]  wgt,
  output logic [ACC_W-1:0]          sum
);

  localparam int PROD_W = DATA_W + WGT_W;

  logic [CH-1:0][PROD_W-1:0] prod;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [PROD_W-1:0] a_x, w_x;
    // Operands widened to the product width so the multiply is full precision.
    assign a_x = {{WGT_W{data[c*DATA_W+DATA_W-1]}}, data[c*DATA_W +: DATA_W]};
    assign w_x = {{DATA_W{wgt[c][WGT_W-1]}}, wgt[c]};
    assign prod[c] = a_x * w_x;
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < CH; c++)
      sum = sum + {{(ACC_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]};
  end

endmodule

// File: rtl/conv_acc_engine.sv
// Windowed multiply-accumulate over TAPS beats of CH channels with a result
// handshake. Optional output clamp: define CONV_ACC_SAT_EN.
module conv_acc_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WGT_W  = WGT_W_DEF,
  parameter int CH     = CH_DEF,
  parameter int TAPS   = TAPS_DEF,
  parameter int ACC_W  = acc_w(DATA_W, WGT_W, CH, TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH*DATA_W-1:0]     in_data,
  input  logic                     w_we,
  input  logic [idx_w(CH)-1:0]     w_ch,
  input  logic [idx_w(TAPS)-1:0]   w_tap,
  input  logic [WGT_W-1:0]         w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data
);

  localparam int TAP_W = idx_w(TAPS);

  state_t                              state, state_d;
  logic [TAP_W-1:0]                    tap, tap_d;
  logic [ACC_W-1:0]                    acc, acc_d;
  logic                                load_out;
  logic [CH-1:0][TAPS-1:0][WGT_W-1:0]  wgt_rf;
  logic [CH-1:0][WGT_W-1:0]            tap_w;
  logic [ACC_W-1:0]                    mac_sum, final_sum, sat_sum;

  // Reads come straight off the registers, so a same-cycle write is not seen.
  always_ff @(posedge clk or posedge rst)
    if (rst)       wgt_rf <= '0;
    else if (w_we) wgt_rf[w_ch][w_tap] <= w_data;

  always_comb
    for (int c = 0; c < CH; c++) tap_w[c] = wgt_rf[c][tap];

  conv_mac #(.DATA_W(DATA_W), .WGT_W(WGT_W), .CH(CH), .ACC_W(ACC_W)) u_mac (
    .data (in_data),
    .wgt  (tap_w),
    .sum  (mac_sum)
  );

  assign final_sum = acc + mac_sum;

`ifdef CONV_ACC_SAT_EN
  localparam int OUT_W = out_w(DATA_W, WGT_W);
  if (ACC_W > OUT_W) begin : g_sat
    logic [ACC_W-OUT_W:0] top;
    assign top = final_sum[ACC_W-1:OUT_W-1];
    always_comb begin
      if (&top || ~|top)        sat_sum = final_sum;
      else if (final_sum[ACC_W-1]) sat_sum = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      else                      sat_sum = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    end
  end else begin : g_nosat
    assign sat_sum = final_sum;
  end
`else
  assign sat_sum = final_sum;
`endif

  assign out_valid = (state == DONE);
  assign in_ready  = (state != DONE) || out_ready;

  always_comb begin
    state_d  = state;
    tap_d    = tap;
    acc_d    = acc;
    load_out = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (clr) begin
          state_d = IDLE;
          tap_d   = '0;
          acc_d   = '0;
        end else if (in_valid) begin
          if (tap == TAP_W'(TAPS-1)) begin
            state_d  = DONE;
            tap_d    = '0;
            acc_d    = '0;
            load_out = 1'b1;
          end else begin
            state_d = ACCUM;
            tap_d   = tap + TAP_W'(1);
            acc_d   = final_sum;
          end
        end
      end
      DONE: begin
        // Handoff: the next window's tap-0 beat lands while the result drains.
        if (out_ready) begin
          if (in_valid) begin
            state_d = ACCUM;
            tap_d   = TAP_W'(1);
            acc_d   = mac_sum;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      tap      <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      state <= state_d;
      tap   <= tap_d;
      acc   <= acc_d;
      if (load_out) out_data <= sat_sum;
    end

endmodule
